// File: rtl/add32_seq_pkg.sv
// Shared arithmetic definitions for the byte-serial 32-bit adder/subtractor.
// FSM encodings and byte geometry live here so every user agrees on them.
package add32_seq_pkg;

    localparam int BYTE_W = 8;
    localparam int BYTES  = 4;
    localparam int DATA_W = BYTE_W * BYTES;
    localparam int IDX_W  = $clog2(BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Selects byte number idx of a full-width word.
    function automatic logic [BYTE_W-1:0] byte_sel(input logic [DATA_W-1:0] w,
                                                   input logic [IDX_W-1:0]  idx);
        logic [BYTE_W-1:0] r;
        r = w[BYTE_W-1:0];
        for (int i = 0; i < BYTES; i++) begin
            if (idx == IDX_W'(i)) r = w[BYTE_W*i +: BYTE_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/add32_seq_add8.sv
// 8-bit ripple-carry adder built from per-bit full-adder gate equations.
// Carry chain is explicit so no arithmetic operator is needed on data bits.
module add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic       co,
    output logic [7:0] s
);

    logic [8:0] c;

    assign c[0] = ci;

    for (genvar gi = 0; gi < 8; gi++) begin : g_fa
        logic p;
        assign p         = a[gi] ^ b[gi];
        assign s[gi]     = p ^ c[gi];
        assign c[gi+1]   = (a[gi] & b[gi]) | (p & c[gi]);
    end

    assign co = c[8];

endmodule

// File: rtl/add32_seq.sv
// Byte-serial 32-bit add/subtract: one shared add8 processes one byte per clock,
// LSB first; a one-cycle done pulse marks the result valid.
module add32_seq
    import add32_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sub,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ci,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] s,
    output logic              co,
    output logic              ov
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  s_q, s_d;
    logic               co_q, co_d;
    logic               ov_q, ov_d;

    logic [BYTE_W-1:0]  add_a, add_b, add_s;
    logic               add_co;

    assign add_a = byte_sel(a_q, idx_q);
    assign add_b = byte_sel(b_q, idx_q);

    add8 u_add8 (
        .a  (add_a),
        .b  (add_b),
        .ci (carry_q),
        .co (add_co),
        .s  (add_s)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                // Subtract is a + ~b + 1, so the inverted operand is latched here.
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : ci;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < BYTES; i++) begin
                    if (idx_q == IDX_W'(i)) s_d[BYTE_W*i +: BYTE_W] = add_s;
                end
                carry_d = add_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(BYTES - 1)) begin
                    state_d = DONE;
                    co_d    = add_co;
                    ov_d    = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                              (add_s[BYTE_W-1] != a_q[DATA_W-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_add32_seq.sv
// Self-checking bench for add32_seq: directed corner cases plus random
// operations against an integer-arithmetic reference model.
module tb_add32_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        co;
    logic        ov;

    int total;
    int bad;

    add32_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ov    (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ov, co, s} from plain unsigned/signed integer arithmetic.
    function automatic logic [33:0] model(input logic sb, input logic [31:0] x,
                                          input logic [31:0] y, input logic c);
        longint sx, sy, r;
        logic [32:0] u;
        logic cy, o;
        sx = $signed(x);
        sy = $signed(y);
        if (sb) begin
            u  = {1'b0, x} - {1'b0, y};
            cy = (x >= y);
            r  = sx - sy;
        end else begin
            u  = {1'b0, x} + {1'b0, y} + {32'd0, c};
            cy = u[32];
            r  = sx + sy + longint'(c);
        end
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {o, cy, u[31:0]};
    endfunction

    // Issues one operation and waits for done; lat = edges after the accepting
    // edge until done is seen (-1 on timeout). Returns inside the DONE cycle.
    task automatic do_op(input logic sb, input logic [31:0] aa, input logic [31:0] bb,
                         input logic cc, output int lat);
        @(negedge clk);
        start = 1'b1; sub = sb; a = aa; b = bb; ci = cc;
        @(posedge clk); #1;
        start = 1'b0;
        sub = 1'($urandom); a = $urandom; b = $urandom; ci = 1'($urandom);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            a = $urandom; b = $urandom;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({s, co, ov, busy, done} !== 36'd0) begin
            bad++;
            $display("FAIL reset_state got s=%h co=%b ov=%b busy=%b done=%b want all 0",
                     s, co, ov, busy, done);
        end
        // First edge with rst_n high must accept a pending start.
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; a = 32'h0000_0003; b = 32'h0000_0004;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL first_start_after_reset busy=%b want 1", busy);
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if ({done, s} !== {1'b1, 32'h0000_0007}) begin
            bad++;
            $display("FAIL first_op_result done=%b s=%h want done=1 s=00000007", done, s);
        end
    endtask

    task automatic test_add_basic;
        int lat;
        logic [33:0] res;
        do_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
        res = {ov, co, s};
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL add_basic_latency got %0d want 4", lat);
        end
        total++;
        if (res !== {1'b0, 1'b0, 32'h0000_0100}) begin
            bad++;
            $display("FAIL add_basic_result got %h want %h", res, {2'b00, 32'h0000_0100});
        end
        // Result must hold into IDLE, and done must be a single cycle.
        @(posedge clk); #1;
        total++;
        if ({done, busy, ov, co, s} !== {2'b00, res}) begin
            bad++;
            $display("FAIL add_hold_idle got done=%b busy=%b res=%h want 0 0 %h",
                     done, busy, {ov, co, s}, res);
        end
    endtask

    task automatic test_full_carry;
        int lat;
        do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat);
        total++;
        if (lat !== 4 || {ov, co, s} !== {1'b0, 1'b1, 32'h0000_0000}) begin
            bad++;
            $display("FAIL full_carry lat=%0d got ov=%b co=%b s=%h want lat=4 ov=0 co=1 s=0",
                     lat, ov, co, s);
        end
    endtask

    task automatic test_sub;
        int lat;
        do_op(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, lat);
        total++;
        if (lat !== 4 || {ov, co, s} !== {1'b0, 1'b0, 32'hFFFF_FFFE}) begin
            bad++;
            $display("FAIL sub_borrow lat=%0d got ov=%b co=%b s=%h want ov=0 co=0 s=fffffffe",
                     lat, ov, co, s);
        end
        do_op(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, lat);
        total++;
        if (lat !== 4 || {ov, co, s} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin
            bad++;
            $display("FAIL sub_overflow lat=%0d got ov=%b co=%b s=%h want ov=1 co=1 s=7fffffff",
                     lat, ov, co, s);
        end
    endtask

    task automatic test_ignore_start;
        int lat, ndone;
        logic [33:0] res, exp;
        exp = model(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 32'h7FFF_FFFF; b = 32'h0000_0001; ci = 1'b0;
        @(posedge clk); #1;
        lat = -1; ndone = 0; res = '0;
        for (int k = 1; k <= 12; k++) begin
            start = (k < 3);
            sub = 1'b1; a = $urandom; b = $urandom; ci = 1'($urandom);
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    res = {ov, co, s};
                end
            end
        end
        start = 1'b0;
        total++;
        if (ndone !== 1 || lat !== 4) begin
            bad++;
            $display("FAIL ignore_start_dones got count=%0d lat=%0d want count=1 lat=4",
                     ndone, lat);
        end
        total++;
        if (res !== exp) begin
            bad++;
            $display("FAIL ignore_start_result got %h want %h", res, exp);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        do_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, lat);
        total++;
        if (lat !== 4 || s !== 32'h2345_6789) begin
            bad++;
            $display("FAIL b2b_first lat=%0d s=%h want lat=4 s=23456789", lat, s);
        end
        start = 1'b1; sub = 1'b0; a = 32'h0000_0010; b = 32'h0000_0020; ci = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_idle busy=%b done=%b want busy=1 done=0", busy, done);
        end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        total++;
        if (lat !== 4 || {ov, co, s} !== {2'b00, 32'h0000_0030}) begin
            bad++;
            $display("FAIL b2b_second lat=%0d got ov=%b co=%b s=%h want lat=4 s=00000030",
                     lat, ov, co, s);
        end
    endtask

    task automatic test_reset_mid;
        int lat, ndone;
        logic [33:0] exp;
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 32'h1122_3344; b = 32'h0101_0101; ci = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({s, co, ov, busy, done} !== 36'd0) begin
            bad++;
            $display("FAIL reset_mid_async got s=%h co=%b ov=%b busy=%b done=%b want all 0",
                     s, co, ov, busy, done);
        end
        #3;
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        total++;
        if (ndone !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_no_done got dones=%0d busy=%b want 0 0", ndone, busy);
        end
        exp = model(1'b0, 32'hCAFE_0001, 32'h0BAD_F00D, 1'b0);
        do_op(1'b0, 32'hCAFE_0001, 32'h0BAD_F00D, 1'b0, lat);
        total++;
        if (lat !== 4 || {ov, co, s} !== exp) begin
            bad++;
            $display("FAIL reset_mid_recover lat=%0d got %h want %h", lat, {ov, co, s}, exp);
        end
    endtask

    task automatic test_random;
        int lat;
        logic sb, cc;
        logic [31:0] x, y;
        logic [33:0] exp;
        for (int n = 0; n < 40; n++) begin
            sb = 1'($urandom);
            cc = 1'($urandom);
            x  = $urandom;
            y  = (n % 8 == 0) ? x : $urandom;
            if (n % 5 == 1) y = ~x;
            exp = model(sb, x, y, cc);
            do_op(sb, x, y, cc, lat);
            total++;
            if (lat !== 4 || {ov, co, s} !== exp) begin
                bad++;
                $display("FAIL random_%0d sub=%b a=%h b=%h ci=%b lat=%0d got %h want %h",
                         n, sb, x, y, cc, lat, {ov, co, s}, exp);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add_basic();
        test_full_carry();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/add32_seq.md
ADD32_SEQ -- requirements
Module: add32_seq

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port start, input, 1 bit: operation request, sampled on the rising edge.
REQ-004 The module SHALL have port sub, input, 1 bit: 0 = add (a+b+ci), 1 = subtract (a-b; ci ignored).
REQ-005 The module SHALL have port a, input, 32 bits: first operand.
REQ-006 The module SHALL have port b, input, 32 bits: second operand.
REQ-007 The module SHALL have port ci, input, 1 bit: carry-in, add mode only.
REQ-008 The module SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-010 The module SHALL have port s, output, 32 bits: result.
REQ-011 The module SHALL have port co, output, 1 bit: carry out of bit 31.
REQ-012 The module SHALL have port ov, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 The module SHALL compute a 32-bit sum with one shared 8-bit adder datapath, one byte per clock, LSB byte first.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 start sampled high in IDLE or DONE SHALL cause the following:
- a is latched.
- b is latched, or ~b when sub=1.
- The carry register is loaded with ci, or 1 when sub=1.
- The byte index is cleared to 0.
- The state goes to RUN.
REQ-016 In RUN, each edge SHALL:
- write the adder sum of operand byte[idx] and the carry register to s[8*idx+7:8*idx];
- store the adder carry-out in the carry register;
- increment idx, a 2-bit counter.
REQ-017 On the RUN edge with idx=3, the FSM SHALL go to DONE, load co with the final carry, and load ov = (a[31]==b'[31]) && (s[31]!=a[31]), where b' is the latched (possibly inverted) operand.
REQ-018 DONE SHALL last exactly one cycle; the FSM then goes to IDLE unless start is high, which is handled per REQ-015.
REQ-019 Latency: if start is sampled at edge T, done SHALL be high during the cycle after edge T+4 (4 RUN cycles, then 1 DONE cycle).
REQ-020 busy SHALL be high exactly while the state is RUN.
REQ-021 done SHALL be high exactly while the state is DONE.
REQ-022 start while busy SHALL be ignored, with no effect on operands, idx, or results.
REQ-023 In DONE and in the following IDLE, s/co/ov SHALL hold the final result until the next accepted start.
REQ-024 During RUN, s/co/ov SHALL be considered undefined (partially updated).
REQ-025 Operand inputs SHALL be sampled only on the accepting edge; later changes to a/b/ci/sub SHALL NOT affect the operation in progress.
REQ-026 Subtract SHALL yield co=1 when no borrow occurs (a>=b unsigned), and co=0 otherwise.

Reset
REQ-027 rst_n low SHALL immediately, regardless of clock, force:
- state to IDLE;
- idx, the carry register, and the operand registers to 0;
- s=0, co=0, ov=0, busy=0, done=0.
REQ-028 Reset asserted mid-operation SHALL abort that operation with no done pulse.
REQ-029 After reset is released, the first start SHALL be honoured on the first rising edge at which rst_n is high.

Structure
REQ-030 The byte adder SHALL be one instance of the team's existing 8-bit ripple adder module add8 (ports a, b, ci, co, s); no other arithmetic operators SHALL be used on data bits.
REQ-031 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the byte count (4) SHALL be defined in the shared arith include/package file, not locally.
REQ-032 The design SHALL be all flip-flops plus combinational muxing of operand bytes into add8, with no latches.

Verification
REQ-033 The bench SHALL cover add 0x000000FF + 0x00000001, ci=0 -> s=0x00000100, co=0, ov=0; done exactly 5 edges after start edge inclusive (REQ-019).
REQ-034 The bench SHALL cover add 0xFFFFFFFF + 0x00000000, ci=1 -> s=0x00000000, co=1, ov=0 (full carry ripple across all 4 bytes).
REQ-035 The bench SHALL cover sub 0x00000005 - 0x00000007 -> s=0xFFFFFFFE, co=0, ov=0; and sub 0x80000000 - 0x00000001 -> s=0x7FFFFFFF, co=1, ov=1.
REQ-036 The bench SHALL cover add 0x7FFFFFFF + 0x00000001 -> s=0x80000000, ov=1, co=0; with a/b changed and start pulsed during RUN, the result SHALL be unchanged and only one done SHALL occur.
REQ-037 The bench SHALL cover back-to-back operations: start high during DONE with new operands (0x10+0x20) -> next done 5 cycles later with s=0x00000030, and no IDLE cycle between the operations.
REQ-038 The bench SHALL cover rst_n low for one half-cycle during RUN (idx=2) -> outputs 0 asynchronously and no done pulse; a subsequent start completes normally.
